// File: rtl/core_seq_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
// States, next-PC select codes and trap-cause codes.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } seq_state_e;

  localparam logic [1:0] PC_SEL_SEQ   = 2'b00;
  localparam logic [1:0] PC_SEL_PCIMM = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IF_TO   = 2'b10;
  localparam logic [1:0] TRAP_DM_TO   = 2'b11;

endpackage

// File: rtl/seq_timer.sv
// Handshake wait timer: clr zeroes it, en counts up, saturating at TIMEOUT.
// Ports: i_clk, clr, en in; expired out (count equals TIMEOUT, pre-increment).
module seq_timer #(
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic i_clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with halt and trap.
// Ports: clock/reset, memory acks, decoder enables in; strobes, PC select, status out.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_if_ack,
  input  logic             i_insn_vld,
  input  logic             i_reg_we,
  input  logic             i_mem_re,
  input  logic             i_mem_we,
  input  logic             i_pc_src_branch,
  input  logic             i_pc_src_jal,
  input  logic             i_pc_src_jalr,
  input  logic             i_br_taken,
  input  logic             i_dmem_ack,
  input  logic             i_halt,
  output logic             o_if_req,
  output logic             o_ir_we,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_rf_we,
  output logic             o_pc_we,
  output logic [1:0]       o_pc_sel,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic             o_halted,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause
);

  seq_state_e       state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       expired;
  logic       tmr_en;
  logic       tmr_clr;
  logic       if_req, ir_we, dmem_req, dmem_we;
  logic       rf_we, pc_we, retire;
  logic [1:0] pc_sel;

  assign tmr_en  = (state_q == S_FETCH) || (state_q == S_MEM);
  // Any state change restarts the wait budget for the next state.
  assign tmr_clr = i_reset || (state_d != state_q) || !tmr_en;

  seq_timer #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_timer (
    .i_clk  (i_clk),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    if_req   = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    pc_sel   = PC_SEL_SEQ;
    unique case (state_q)
      S_FETCH: begin
        if_req = 1'b1;
        // An ack on the expiry cycle still completes the fetch.
        if (i_if_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = TRAP_IF_TO;
        end
      end
      S_DECODE: begin
        if (!i_insn_vld) begin
          state_d = S_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = (i_mem_re || i_mem_we) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = i_mem_we;
        if (i_dmem_ack) begin
          state_d = S_WB;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = TRAP_DM_TO;
        end
      end
      S_WB: begin
        rf_we  = i_reg_we;
        pc_we  = 1'b1;
        retire = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (i_pc_src_jalr) begin
          pc_sel = PC_SEL_JALR;
        end else if (i_pc_src_jal || (i_pc_src_branch && i_br_taken)) begin
          pc_sel = PC_SEL_PCIMM;
        end
        state_d = i_halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!i_halt) begin
          state_d = S_FETCH;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_FETCH;
      cause_q <= TRAP_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset abandons the current instruction in the same cycle.
  assign o_if_req     = if_req & ~i_reset;
  assign o_ir_we      = ir_we & ~i_reset;
  assign o_dmem_req   = dmem_req & ~i_reset;
  assign o_dmem_we    = dmem_we & ~i_reset;
  assign o_rf_we      = rf_we & ~i_reset;
  assign o_pc_we      = pc_we & ~i_reset;
  assign o_retire     = retire & ~i_reset;
  assign o_pc_sel     = i_reset ? PC_SEL_SEQ : pc_sel;
  assign o_retire_cnt = i_reset ? '0 : cnt_q;
  assign o_halted     = ~i_reset & (state_q == S_HALT);
  assign o_trap       = ~i_reset & (state_q == S_TRAP);
  assign o_trap_cause = i_reset ? TRAP_NONE : cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer against a per-instruction cycle model.
// Each instruction is expanded into expected per-cycle outputs and compared.
module tb_core_sequencer;

  localparam int TO = 4;
  localparam int TW = 8;
  localparam int CW = 5;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam int K_JAL   = 4;
  localparam int K_JALR  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_reset, i_if_ack, i_insn_vld, i_reg_we, i_mem_re, i_mem_we;
  logic i_pc_src_branch, i_pc_src_jal, i_pc_src_jalr, i_br_taken;
  logic i_dmem_ack, i_halt;
  logic o_if_req, o_ir_we, o_dmem_req, o_dmem_we, o_rf_we, o_pc_we;
  logic [1:0] o_pc_sel;
  logic o_retire;
  logic [CW-1:0] o_retire_cnt;
  logic o_halted, o_trap;
  logic [1:0] o_trap_cause;

  core_sequencer #(
    .TIMEOUT(TO),
    .TMR_W  (TW),
    .CNT_W  (CW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_if_ack       (i_if_ack),
    .i_insn_vld     (i_insn_vld),
    .i_reg_we       (i_reg_we),
    .i_mem_re       (i_mem_re),
    .i_mem_we       (i_mem_we),
    .i_pc_src_branch(i_pc_src_branch),
    .i_pc_src_jal   (i_pc_src_jal),
    .i_pc_src_jalr  (i_pc_src_jalr),
    .i_br_taken     (i_br_taken),
    .i_dmem_ack     (i_dmem_ack),
    .i_halt         (i_halt),
    .o_if_req       (o_if_req),
    .o_ir_we        (o_ir_we),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .o_rf_we        (o_rf_we),
    .o_pc_we        (o_pc_we),
    .o_pc_sel       (o_pc_sel),
    .o_retire       (o_retire),
    .o_retire_cnt   (o_retire_cnt),
    .o_halted       (o_halted),
    .o_trap         (o_trap),
    .o_trap_cause   (o_trap_cause)
  );

  typedef struct packed {
    logic reset, if_ack, insn_vld, reg_we, mem_re, mem_we;
    logic br, jal, jalr, br_taken, dmem_ack, halt;
  } stim_t;

  typedef struct packed {
    logic          if_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
    logic [1:0]    pc_sel;
    logic          retire;
    logic [CW-1:0] cnt;
    logic          halted, trap;
    logic [1:0]    cause;
  } exp_t;

  stim_t sq[$];
  exp_t  eq[$];
  exp_t  expq[$];
  exp_t  ev, av;
  logic [CW-1:0] mcnt = '0;
  int checks = 0;
  int errors = 0;

  function automatic stim_t noise();
    logic [31:0] r;
    stim_t s;
    r = $urandom;
    s = stim_t'(r[11:0]);
    s.reset = 1'b0;
    return s;
  endfunction

  function automatic stim_t with_dec(stim_t d);
    stim_t s;
    s = noise();
    s.insn_vld = d.insn_vld;
    s.reg_we   = d.reg_we;
    s.mem_re   = d.mem_re;
    s.mem_we   = d.mem_we;
    s.br       = d.br;
    s.jal      = d.jal;
    s.jalr     = d.jalr;
    s.br_taken = d.br_taken;
    return s;
  endfunction

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.cnt = mcnt;
    return e;
  endfunction

  function automatic void add(stim_t s, exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endfunction

  // Expand one instruction into its cycles; returns the trap cause it ends in.
  function automatic logic [1:0] build(int kind, int fw, int dw, bit legal,
                                       int hc, bit tk);
    stim_t d, s;
    exp_t e;
    int n;
    sq.delete();
    eq.delete();
    d = '0;
    d.insn_vld = legal;
    d.reg_we   = (kind != K_STORE) && (kind != K_BR);
    d.mem_re   = (kind == K_LOAD);
    d.mem_we   = (kind == K_STORE);
    d.br       = (kind == K_BR);
    d.jal      = (kind == K_JAL);
    d.jalr     = (kind == K_JALR);
    d.br_taken = tk;
    n = (fw > TO) ? TO + 1 : fw + 1;
    for (int i = 0; i < n; i++) begin
      s = noise();
      s.if_ack = (fw <= TO) && (i == fw);
      e = base();
      e.if_req = 1'b1;
      e.ir_we = s.if_ack;
      add(s, e);
    end
    if (fw > TO) return 2'b10;
    add(with_dec(d), base());
    if (!legal) return 2'b01;
    add(with_dec(d), base());
    if (d.mem_re || d.mem_we) begin
      n = (dw > TO) ? TO + 1 : dw + 1;
      for (int i = 0; i < n; i++) begin
        s = with_dec(d);
        s.dmem_ack = (dw <= TO) && (i == dw);
        e = base();
        e.dmem_req = 1'b1;
        e.dmem_we = d.mem_we;
        add(s, e);
      end
      if (dw > TO) return 2'b11;
    end
    s = with_dec(d);
    s.halt = (hc > 0);
    e = base();
    e.rf_we = d.reg_we;
    e.pc_we = 1'b1;
    e.retire = 1'b1;
    if (d.jalr) e.pc_sel = 2'b10;
    else if (d.jal || (d.br && tk)) e.pc_sel = 2'b01;
    else e.pc_sel = 2'b00;
    add(s, e);
    mcnt = mcnt + 1'b1;
    for (int i = 0; i < hc; i++) begin
      s = noise();
      s.halt = (i != hc - 1);
      e = base();
      e.halted = 1'b1;
      add(s, e);
    end
    return 2'b00;
  endfunction

  task automatic drive(stim_t s);
    i_reset         = s.reset;
    i_if_ack        = s.if_ack;
    i_insn_vld      = s.insn_vld;
    i_reg_we        = s.reg_we;
    i_mem_re        = s.mem_re;
    i_mem_we        = s.mem_we;
    i_pc_src_branch = s.br;
    i_pc_src_jal    = s.jal;
    i_pc_src_jalr   = s.jalr;
    i_br_taken      = s.br_taken;
    i_dmem_ack      = s.dmem_ack;
    i_halt          = s.halt;
  endtask

  task automatic put(stim_t s, exp_t e);
    drive(s);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    stim_t s;
    mcnt = '0;
    for (int i = 0; i < n; i++) begin
      s = noise();
      s.reset = 1'b1;
      put(s, '0);
    end
  endtask

  task automatic play(int rst_at);
    for (int i = 0; i < sq.size() && i != rst_at; i++) begin
      put(sq[i], eq[i]);
    end
    if (rst_at >= 0 && rst_at < sq.size()) do_reset(1);
  endtask

  task automatic trap_idle(int n, logic [1:0] c);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = base();
      e.trap = 1'b1;
      e.cause = c;
      put(noise(), e);
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ev = expq.pop_front();
      av.if_req   = o_if_req;
      av.ir_we    = o_ir_we;
      av.dmem_req = o_dmem_req;
      av.dmem_we  = o_dmem_we;
      av.rf_we    = o_rf_we;
      av.pc_we    = o_pc_we;
      av.pc_sel   = o_pc_sel;
      av.retire   = o_retire;
      av.cnt      = o_retire_cnt;
      av.halted   = o_halted;
      av.trap     = o_trap;
      av.cause    = o_trap_cause;
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL cycle t=%0t got=%h exp=%h", $time, av, ev);
      end
    end
  end

  initial begin
    logic [1:0] c;
    int k, fw, dw, hc, ra, nreq;
    bit legal, tk;
    @(posedge clk);
    #1;
    do_reset(2);

    c = build(K_ALU, 0, 0, 1, 0, 0);
    chk("addi_len", sq.size(), 4);
    chk("addi_wb", {eq[3].rf_we, eq[3].pc_sel, eq[3].retire}, 4'b1001);
    play(-1);
    chk("addi_cnt", 32'(o_retire_cnt), 1);

    c = build(K_LOAD, 0, 3, 1, 0, 0);
    nreq = 0;
    foreach (eq[i]) nreq += int'(eq[i].dmem_req);
    chk("lw_len", sq.size(), 8);
    chk("lw_req_cycles", nreq, 4);
    chk("lw_wb_rfwe", eq[7].rf_we, 1);
    play(-1);

    c = build(K_BR, 0, 0, 1, 0, 1);
    chk("beq_t_wb", {eq[3].rf_we, eq[3].pc_sel}, 3'b001);
    play(-1);
    c = build(K_BR, 0, 0, 1, 0, 0);
    chk("beq_nt_sel", eq[3].pc_sel, 0);
    play(-1);
    c = build(K_JALR, 0, 0, 1, 0, 0);
    chk("jalr_sel", eq[3].pc_sel, 2);
    play(-1);
    c = build(K_ALU, 1, 0, 1, 3, 0);
    play(-1);
    c = build(K_STORE, 2, 1, 1, 0, 0);
    play(-1);
    chk("cnt_after7", 32'(o_retire_cnt), 7);

    c = build(K_LOAD, 0, 3, 1, 0, 0);
    play(4);
    c = build(K_ALU, 0, 0, 1, 0, 0);
    play(-1);
    chk("rst_cnt_clear", 32'(o_retire_cnt), 1);

    c = build(K_ALU, 0, 0, 0, 0, 0);
    chk("ill_model", c, 1);
    play(-1);
    trap_idle(22, c);
    chk("ill_trap", {o_trap, o_trap_cause}, 3'b101);
    do_reset(1);

    c = build(K_ALU, TO + 1, 0, 1, 0, 0);
    chk("ifto_len", sq.size(), 5);
    play(-1);
    trap_idle(4, c);
    chk("ifto_trap", {o_trap, o_trap_cause}, 3'b110);
    do_reset(1);

    c = build(K_ALU, TO, 0, 1, 0, 0);
    chk("if_late_len", sq.size(), 8);
    play(-1);
    chk("if_late_notrap", o_trap, 0);

    c = build(K_STORE, 0, TO + 1, 1, 0, 0);
    play(-1);
    trap_idle(3, c);
    chk("dmto_trap", {o_trap, o_trap_cause}, 3'b111);
    do_reset(2);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 5);
      fw = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
      dw = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
      legal = ($urandom_range(0, 19) != 0);
      hc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      tk = 1'($urandom_range(0, 1));
      c = build(k, fw, dw, legal, hc, tk);
      if (c != 2'b00) begin
        play(-1);
        trap_idle($urandom_range(1, 4), c);
        do_reset($urandom_range(1, 2));
      end else begin
        ra = ($urandom_range(0, 24) == 0) ? $urandom_range(0, sq.size() - 1) : -1;
        play(ra);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
